// File: rtl/al_cmd_responder_if.sv
// Signal bundle between the auto-load sequencer, the command responder and the flash pins.
// The slave modport is the responder side; the master modport is the sequencer/flash side.
interface al_cmd_responder_if;
  logic        al_execute;
  logic [1:0]  al_op;
  logic [22:0] al_addr;
  logic [15:0] al_cmd_data_in;
  logic        clr_al_done;
  logic        al_done;
  logic        al_busy;
  logic        al_err;
  logic [15:0] al_rd_data;
  logic [22:0] fl_addr;
  logic [15:0] fl_dq_out;
  logic [15:0] fl_dq_in;
  logic        fl_dq_oe;
  logic        fl_ce_b;
  logic        fl_oe_b;
  logic        fl_we_b;

  modport slave (
    input  al_execute, al_op, al_addr, al_cmd_data_in, clr_al_done, fl_dq_in,
    output al_done, al_busy, al_err, al_rd_data,
    output fl_addr, fl_dq_out, fl_dq_oe, fl_ce_b, fl_oe_b, fl_we_b
  );

  modport master (
    output al_execute, al_op, al_addr, al_cmd_data_in, clr_al_done, fl_dq_in,
    input  al_done, al_busy, al_err, al_rd_data,
    input  fl_addr, fl_dq_out, fl_dq_oe, fl_ce_b, fl_oe_b, fl_we_b
  );
endinterface

// File: rtl/al_cmd_responder.sv
// Executes one auto-load command (NOP/WRITE/READ/POLL) as timed flash strobe sequences.
// Flash strobes are decoded from the state register so an async reset returns them high at once.
module al_cmd_responder #(
  parameter int T_WE     = 4,
  parameter int T_HOLD   = 2,
  parameter int T_RD     = 6,
  parameter int MAX_POLL = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  al_cmd_responder_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, SETUP, WR_PULSE, WR_HOLD, RD_WAIT, RD_CAP, POLL_REC, DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_POLL  = 2'b11
  } op_t;

  // SETUP already drives OE_B low, so it counts as the first of the T_RD access cycles.
  localparam logic [3:0]  WE_LAST    = 4'(T_WE - 1);
  localparam logic [3:0]  HOLD_LAST  = 4'(T_HOLD - 1);
  localparam logic [3:0]  RD_LAST    = (T_RD > 1) ? 4'(T_RD - 2) : 4'd0;
  localparam logic [16:0] POLL_LIMIT = 17'(MAX_POLL);

  state_t      state;
  state_t      state_next;
  op_t         op_q;
  logic [22:0] addr_q;
  logic [15:0] data_q;
  logic [15:0] rd_data_q;
  logic        done_q;
  logic        err_q;
  logic [3:0]  wait_cnt;
  logic [15:0] poll_cnt;

  logic        accept;
  logic        poll_hit;
  logic        poll_timeout;
  logic        poll_miss;
  logic        ce_b;
  logic        oe_b;
  logic        we_b;
  logic        dq_oe;

  assign accept       = (state == IDLE) && bus.al_execute;
  assign poll_hit     = rd_data_q[7];
  assign poll_timeout = ({1'b0, poll_cnt} + 17'd1) >= POLL_LIMIT;
  assign poll_miss    = (state == RD_CAP) && (op_q == OP_POLL) && !poll_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = (op_t'(bus.al_op) == OP_NOP) ? DONE : SETUP;
        end
      end
      SETUP: begin
        if (op_q == OP_WRITE) begin
          state_next = WR_PULSE;
        end else if (T_RD > 1) begin
          state_next = RD_WAIT;
        end else begin
          state_next = RD_CAP;
        end
      end
      WR_PULSE: begin
        if (wait_cnt == WE_LAST) state_next = WR_HOLD;
      end
      WR_HOLD: begin
        if (wait_cnt == HOLD_LAST) state_next = DONE;
      end
      RD_WAIT: begin
        if (wait_cnt == RD_LAST) state_next = RD_CAP;
      end
      RD_CAP: begin
        if (poll_miss && !poll_timeout) begin
          state_next = POLL_REC;
        end else begin
          state_next = DONE;
        end
      end
      POLL_REC: state_next = SETUP;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    ce_b  = 1'b1;
    oe_b  = 1'b1;
    we_b  = 1'b1;
    dq_oe = 1'b0;
    case (state)
      SETUP: begin
        ce_b = 1'b0;
        if (op_q == OP_WRITE) begin
          dq_oe = 1'b1;
        end else begin
          oe_b = 1'b0;
        end
      end
      WR_PULSE: begin
        ce_b  = 1'b0;
        we_b  = 1'b0;
        dq_oe = 1'b1;
      end
      WR_HOLD: begin
        ce_b  = 1'b0;
        dq_oe = 1'b1;
      end
      RD_WAIT, RD_CAP: begin
        ce_b = 1'b0;
        oe_b = 1'b0;
      end
      default: begin
        ce_b  = 1'b1;
        oe_b  = 1'b1;
        we_b  = 1'b1;
        dq_oe = 1'b0;
      end
    endcase
  end

  // Phase timer restarts on every state change so each timed phase counts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= 4'd0;
    end else if (state_next != state) begin
      wait_cnt <= 4'd0;
    end else begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      poll_cnt <= 16'd0;
    end else if (accept) begin
      poll_cnt <= 16'd0;
    end else if (poll_miss) begin
      poll_cnt <= poll_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= OP_NOP;
      addr_q <= 23'd0;
      data_q <= 16'd0;
    end else if (accept) begin
      op_q   <= op_t'(bus.al_op);
      addr_q <= bus.al_addr;
      data_q <= bus.al_cmd_data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= 16'd0;
    end else if ((state_next == RD_CAP) && (state != RD_CAP)) begin
      rd_data_q <= bus.fl_dq_in;
    end
  end

  // Completion in DONE outranks a coincident clear request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (accept) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (state == DONE) begin
        done_q <= 1'b1;
      end else if (bus.clr_al_done) begin
        done_q <= 1'b0;
      end
      if (poll_miss && poll_timeout) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.al_done    = done_q;
  assign bus.al_busy    = (state != IDLE);
  assign bus.al_err     = err_q;
  assign bus.al_rd_data = rd_data_q;
  assign bus.fl_addr    = addr_q;
  assign bus.fl_dq_out  = data_q;
  assign bus.fl_dq_oe   = dq_oe;
  assign bus.fl_ce_b    = ce_b;
  assign bus.fl_oe_b    = oe_b;
  assign bus.fl_we_b    = we_b;

endmodule
